dht_frame_decoder: RTL and testbench
====================================

Name: dht_frame_decoder

Overview:
Sits directly downstream of the DHT humidity/temperature sensor reader. It consumes the reader's 40-bit HYM2 frame and validates the checksum byte. It extracts the integer humidity and temperature bytes and converts them to 3-digit BCD with a sequential double-dabble. It publishes registered display-ready values with a valid strobe, and also reports checksum errors and sensor staleness.

Parameters:
STALE_PERIODS, 3, number of flag_five_sec rising edges without a valid frame before sensor_fault asserts (1..15)
ERR_CNT_W, 8, width of the saturating checksum-error counter

Ports:
clk1M  in  1  1 MHz system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
HYM2  in  40  frame from sensor reader: [39:32] RH int, [31:24] RH dec, [23:16] T int, [15:8] T dec, [7:0] checksum
flag_five_sec  in  1  5 s strobe, same signal that triggers the reader
hum_bcd  out  12  humidity integer part, BCD hundreds/tens/units
temp_bcd  out  12  temperature integer part, BCD hundreds/tens/units
data_valid  out  1  one-cycle pulse when hum_bcd/temp_bcd update
crc_err  out  1  one-cycle pulse on checksum mismatch
err_cnt  out  ERR_CNT_W  saturating count of checksum errors
sensor_fault  out  1  level; no valid frame for STALE_PERIODS strobes
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): all outputs 0. State = IDLE. Internal last_seen = 0, stale counter = 0, flag_five_sec edge-detect shift register = 0.
- Input handling: HYM2 and flag_five_sec are registered once (sync stage) before use.
- last_seen rules: cleared whenever the registered HYM2 == 0, in any state. This lets an identical reading after the reader's start-of-cycle clear be processed again.
- Capture: in IDLE, when registered HYM2 != 0 and != last_seen:
  - frame_reg <= HYM2 and last_seen <= HYM2.
  - State -> CHECK on that edge (E0).
- A frame change while busy is not lost. It is captured on the first IDLE cycle where the capture condition still holds.
- CHECK (edge E1): sum = (b4 + b3 + b2 + b1) mod 256, 8-bit wrap.
  - Match with b0: load double-dabble shifters with b4 and b2, iteration counter = 0, state -> CONV.
  - Mismatch: crc_err pulses for one cycle, err_cnt increments saturating at all-ones, state -> IDLE, hum_bcd/temp_bcd unchanged.
- CONV (edges E2..E9): exactly 8 iterations, both bytes in parallel. Each iteration adds 3 to any BCD nibble >= 5, then shifts left by one.
- DONE (edge E10):
  - hum_bcd/temp_bcd <= results and data_valid <= 1 for exactly one cycle.
  - stale counter <= 0 and sensor_fault <= 0.
  - State -> IDLE.
- Latency: data_valid is high in the cycle after E10, i.e. 10 clocks after the capture edge E0.
- Staleness:
  - On each flag_five_sec rising edge, the stale counter increments, saturating at STALE_PERIODS.
  - sensor_fault <= 1 when the counter reaches STALE_PERIODS.
  - On a same-cycle clash, the DONE clear wins over the increment.
- crc_err and data_valid are never high together.
- Byte range: 0..255 maps to BCD 0x000..0x255. Decimal bytes b3/b1 take part only in the checksum.

Test Plan:
- Valid frame: HYM2 = 0x37_00_18_00_4F after reset -> 10 clocks after capture: hum_bcd = 0x055, temp_bcd = 0x024, one-cycle data_valid, crc_err = 0, busy high for exactly 10 cycles.
- Bad checksum: HYM2 = 0x37_00_18_00_50 -> crc_err pulse at E1+1, err_cnt = 1, no data_valid, outputs keep their previous values; 256 bad frames -> err_cnt stays 255.
- Checksum wrap and max range: HYM2 = 0xFF_00_FF_00_FE -> valid, hum_bcd = 0x255, temp_bcd = 0x255.
- Repeat and hold:
  - 0x37_00_18_00_4F, then the same value held -> only one data_valid.
  - HYM2 -> 0 then the same value again -> second data_valid.
  - A new frame arriving mid-CONV -> processed right after return to IDLE.
- Staleness: 3 flag_five_sec edges with no frames -> sensor_fault = 1 after the third edge; next valid frame -> sensor_fault = 0 with data_valid.
- Reset mid-operation: assert rst during CONV -> all outputs 0 immediately, busy = 0; after release, the same nonzero HYM2 is re-captured and decoded correctly.

Source files
------------

// File: rtl/dht_frame_decoder.sv
// Validates the 40-bit HYM2 frame from the DHT reader, converts the integer humidity and
// temperature bytes to BCD with an 8-step double-dabble, and tracks checksum errors and staleness.
module dht_frame_decoder #(
    parameter int STALE_PERIODS = 3,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk1M,
    input  logic                 rst,
    input  logic [39:0]          HYM2,
    input  logic                 flag_five_sec,
    output logic [11:0]          hum_bcd,
    output logic [11:0]          temp_bcd,
    output logic                 data_valid,
    output logic                 crc_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 sensor_fault,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CONV,
        ST_DONE
    } state_t;

    localparam logic [3:0] STALE_MAX = 4'(STALE_PERIODS);

    state_t               state_q;
    logic [39:0]          hym_q;
    logic [39:0]          last_seen_q;
    logic [39:0]          frame_q;
    logic                 flag_q;
    logic                 flag_prev_q;
    logic [19:0]          hum_sh_q;
    logic [19:0]          temp_sh_q;
    logic [2:0]           iter_q;
    logic [11:0]          hum_q;
    logic [11:0]          temp_q;
    logic                 valid_q;
    logic                 crc_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic [3:0]           stale_q;
    logic                 fault_q;

    logic [7:0]           sum;
    logic                 capture;
    logic                 flag_rise;
    logic [3:0]           stale_d;

    // One double-dabble step: bias every BCD nibble >= 5 by 3, then shift the whole word left.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int n = 0; n < 3; n++) begin
            if (t[8+4*n +: 4] >= 4'd5) begin
                t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    assign sum       = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    assign capture   = (hym_q != '0) && (hym_q != last_seen_q);
    assign flag_rise = flag_q & ~flag_prev_q;
    assign stale_d   = (stale_q == STALE_MAX) ? stale_q : stale_q + 4'd1;

    always_ff @(posedge clk1M or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hym_q       <= '0;
            last_seen_q <= '0;
            frame_q     <= '0;
            flag_q      <= 1'b0;
            flag_prev_q <= 1'b0;
            hum_sh_q    <= '0;
            temp_sh_q   <= '0;
            iter_q      <= '0;
            hum_q       <= '0;
            temp_q      <= '0;
            valid_q     <= 1'b0;
            crc_q       <= 1'b0;
            err_q       <= '0;
            stale_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here; when two assignments hit the same register in
            // one cycle the later one wins, which is how the DONE clear overrides the stale increment.
            hym_q       <= HYM2;
            flag_q      <= flag_five_sec;
            flag_prev_q <= flag_q;
            valid_q     <= 1'b0;
            crc_q       <= 1'b0;

            if (flag_rise) begin
                stale_q <= stale_d;
                if (stale_d == STALE_MAX) fault_q <= 1'b1;
            end

            // A zero frame marks the reader's start-of-cycle clear; forget the last reading.
            if (hym_q == '0) last_seen_q <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        frame_q     <= hym_q;
                        last_seen_q <= hym_q;
                        state_q     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (sum == frame_q[7:0]) begin
                        hum_sh_q  <= {12'd0, frame_q[39:32]};
                        temp_sh_q <= {12'd0, frame_q[23:16]};
                        iter_q    <= '0;
                        state_q   <= ST_CONV;
                    end else begin
                        crc_q   <= 1'b1;
                        if (err_q != '1) err_q <= err_q + 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    hum_sh_q  <= dd_step(hum_sh_q);
                    temp_sh_q <= dd_step(temp_sh_q);
                    iter_q    <= iter_q + 3'd1;
                    if (iter_q == 3'd7) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    hum_q   <= hum_sh_q[19:8];
                    temp_q  <= temp_sh_q[19:8];
                    valid_q <= 1'b1;
                    stale_q <= '0;
                    fault_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hum_bcd      = hum_q;
    assign temp_bcd     = temp_q;
    assign data_valid   = valid_q;
    assign crc_err      = crc_q;
    assign err_cnt      = err_q;
    assign sensor_fault = fault_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dht_frame_decoder.sv
// Directed bench for dht_frame_decoder: a frame-level reference model checked every cycle,
// plus literal expectations for the headline scenarios.
`timescale 1ns/1ps
module tb_dht_frame_decoder;

    localparam int STALE = 3;

    logic        clk1M = 1'b0;
    logic        rst   = 1'b1;
    logic [39:0] HYM2  = '0;
    logic        flag_five_sec = 1'b0;
    logic [11:0] hum_bcd, temp_bcd;
    logic        data_valid, crc_err, sensor_fault, busy;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    dht_frame_decoder #(.STALE_PERIODS(STALE), .ERR_CNT_W(8)) dut (
        .clk1M(clk1M), .rst(rst), .HYM2(HYM2), .flag_five_sec(flag_five_sec),
        .hum_bcd(hum_bcd), .temp_bcd(temp_bcd), .data_valid(data_valid), .crc_err(crc_err),
        .err_cnt(err_cnt), .sensor_fault(sensor_fault), .busy(busy)
    );

    always #500 clk1M = ~clk1M;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    int          m_phase;   // 0 idle, 1 checking, 2..10 converting/publishing
    int          m_stale;
    logic [39:0] m_hq, m_frame, m_last;
    logic        m_fq, m_fprev, m_rise, m_done;
    logic [11:0] e_hum, e_temp;
    logic        e_dv, e_crc, e_fault;
    int          e_err;

    initial begin
        m_phase = 0; m_stale = 0; m_hq = '0; m_frame = '0; m_last = '0;
        m_fq = 0; m_fprev = 0; e_hum = '0; e_temp = '0; e_dv = 0; e_crc = 0; e_fault = 0; e_err = 0;
    end

    always @(posedge clk1M or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_stale = 0; m_hq = '0; m_frame = '0; m_last = '0;
            m_fq = 0; m_fprev = 0; e_hum = '0; e_temp = '0; e_dv = 0; e_crc = 0; e_fault = 0; e_err = 0;
        end else begin
            m_rise = m_fq && !m_fprev;
            m_done = 0;
            e_dv   = 0;
            e_crc  = 0;
            if (m_phase == 0) begin
                if (m_hq != 0 && m_hq != m_last) begin
                    m_frame = m_hq; m_last = m_hq; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (((int'(m_frame[39:32]) + int'(m_frame[31:24]) + int'(m_frame[23:16])
                      + int'(m_frame[15:8])) % 256) == int'(m_frame[7:0])) begin
                    m_phase = 2;
                end else begin
                    e_crc = 1;
                    if (e_err < 255) e_err++;
                    m_phase = 0;
                end
            end else if (m_phase < 10) begin
                m_phase++;
            end else begin
                e_hum  = to_bcd(int'(m_frame[39:32]));
                e_temp = to_bcd(int'(m_frame[23:16]));
                e_dv   = 1;
                m_done = 1;
                m_phase = 0;
            end
            if (m_hq == 0) m_last = '0;
            if (m_done) begin
                m_stale = 0; e_fault = 0;
            end else if (m_rise) begin
                if (m_stale < STALE) m_stale++;
                if (m_stale == STALE) e_fault = 1;
            end
            m_fprev = m_fq;
            m_fq    = flag_five_sec;
            m_hq    = HYM2;
        end
    end

    always @(posedge clk1M) begin
        #1;
        check("hum_bcd", hum_bcd, e_hum);
        check("temp_bcd", temp_bcd, e_temp);
        check("data_valid", data_valid, e_dv);
        check("crc_err", crc_err, e_crc);
        check("err_cnt", err_cnt, 40'(e_err));
        check("sensor_fault", sensor_fault, e_fault);
        check("busy", busy, m_phase != 0);
        check("dv_crc_exclusive", data_valid & crc_err, 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_frame(input int max_cyc, output int nb, output int ndv, output int ncrc);
        bit seen;
        bit ended;
        nb = 0; ndv = 0; ncrc = 0; seen = 0; ended = 0;
        for (int i = 0; i < max_cyc && !ended; i++) begin
            @(negedge clk1M);
            if (busy) begin nb++; seen = 1; end
            if (data_valid) ndv++;
            if (crc_err) ncrc++;
            if (seen && !busy) ended = 1;
        end
        check("frame_finished", ended, 1);
    endtask

    task automatic count_dv(input int cycles, output int ndv);
        ndv = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk1M);
            if (data_valid) ndv++;
        end
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk1M);
        check("busy_start", busy, 1);
    endtask

    task automatic pulse_flag();
        @(negedge clk1M) flag_five_sec = 1'b1;
        @(negedge clk1M) flag_five_sec = 1'b0;
        repeat (4) @(negedge clk1M);
    endtask

    localparam logic [39:0] F_GOOD = 40'h37_00_18_00_4F;
    localparam logic [39:0] F_BAD0 = 40'h37_00_18_00_50;
    localparam logic [39:0] F_BAD1 = 40'h37_00_18_00_51;
    localparam logic [39:0] F_MAX  = 40'hFF_00_FF_00_FE;
    localparam logic [39:0] F_A    = 40'h19_00_63_00_7C;
    localparam logic [39:0] F_B    = 40'h64_00_07_00_6B;

    initial begin
        int nb, ndv, ncrc;

        repeat (3) @(negedge clk1M);
        check("rst_hum", hum_bcd, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_cnt, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk1M);

        // Valid frame: 55 %RH, 24 C.
        HYM2 = F_GOOD;
        run_frame(30, nb, ndv, ncrc);
        check("good_busy_cycles", nb, 10);
        check("good_dv_count", ndv, 1);
        check("good_crc_count", ncrc, 0);
        check("good_hum", hum_bcd, 12'h055);
        check("good_temp", temp_bcd, 12'h024);

        // Same value held: no second publication.
        count_dv(20, ndv);
        check("hold_no_dv", ndv, 0);

        // Bad checksum keeps the previous reading.
        HYM2 = F_BAD0;
        run_frame(20, nb, ndv, ncrc);
        check("bad_crc_count", ncrc, 1);
        check("bad_dv_count", ndv, 0);
        check("bad_err_cnt", err_cnt, 1);
        check("bad_hum_kept", hum_bcd, 12'h055);
        check("bad_temp_kept", temp_bcd, 12'h024);

        // 256 more bad frames saturate the counter.
        for (int i = 0; i < 256; i++) begin
            HYM2 = (i % 2 == 0) ? F_BAD1 : F_BAD0;
            run_frame(12, nb, ndv, ncrc);
        end
        check("err_saturated", err_cnt, 255);

        // Checksum wrap, full-scale bytes.
        HYM2 = F_MAX;
        run_frame(30, nb, ndv, ncrc);
        check("max_dv_count", ndv, 1);
        check("max_hum", hum_bcd, 12'h255);
        check("max_temp", temp_bcd, 12'h255);

        // Repeat after the reader's clear is processed again.
        HYM2 = F_GOOD;
        run_frame(30, nb, ndv, ncrc);
        check("repeat1_dv", ndv, 1);
        HYM2 = '0;
        repeat (3) @(negedge clk1M);
        HYM2 = F_GOOD;
        run_frame(30, nb, ndv, ncrc);
        check("repeat2_dv", ndv, 1);

        // New frame arriving mid-conversion is picked up afterwards.
        HYM2 = F_A;
        wait_busy();
        repeat (4) @(negedge clk1M);
        HYM2 = F_B;
        count_dv(40, ndv);
        check("midconv_dv_count", ndv, 2);
        check("midconv_hum", hum_bcd, 12'h100);
        check("midconv_temp", temp_bcd, 12'h007);

        // Staleness after three strobes, cleared by the next good frame.
        pulse_flag();
        pulse_flag();
        check("stale_after_2", sensor_fault, 0);
        pulse_flag();
        check("stale_after_3", sensor_fault, 1);
        HYM2 = F_GOOD;
        run_frame(30, nb, ndv, ncrc);
        check("stale_clear_dv", ndv, 1);
        check("stale_cleared", sensor_fault, 0);

        // Reset in the middle of a conversion.
        HYM2 = F_A;
        wait_busy();
        repeat (4) @(negedge clk1M);
        rst = 1'b1;
        #1;
        check("midrst_hum", hum_bcd, 0);
        check("midrst_temp", temp_bcd, 0);
        check("midrst_err", err_cnt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dv", data_valid, 0);
        repeat (2) @(negedge clk1M);
        rst = 1'b0;
        run_frame(30, nb, ndv, ncrc);
        check("postrst_dv", ndv, 1);
        check("postrst_hum", hum_bcd, 12'h025);
        check("postrst_temp", temp_bcd, 12'h099);

        repeat (3) @(negedge clk1M);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
